sync_updown_counter: RTL



---
 rtl/counter_pkg.sv | 13 +
 rtl/sync_updown_counter_next_state.sv | 67 ++++++
 rtl/sync_updown_counter.sv | 57 +++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and load clamping.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Loads outside the count range pin to the top legal value instead of aliasing.
  function automatic int clamp_load(input int value, input int modulus);
    if (value >= modulus) return modulus - 1;
    return value;
  endfunction

endpackage

// File: rtl/sync_updown_counter_next_state.sv
// Combinational next-count and wrap logic for sync_updown_counter.
// SYNC_UPDOWN_SAT_EN selects saturating instead of modulo behaviour at the ends.
module counter_next_state
  import counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 16
) (
  input  logic [W-1:0] out,
  input  logic         up_dn,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] next_out,
  output logic         wrap_next
);

  localparam logic [W:0]   LP_MOD = (W+1)'(MOD);
  localparam logic [W-1:0] LP_TOP = W'(MOD - 1);

  logic [W:0]   w_cur;
  logic [W:0]   w_inc;
  logic [W:0]   w_dec;
  logic [W-1:0] w_load;

  // One extra bit: w_inc reaching MOD flags the top, w_dec[W] is the borrow out of 0.
  assign w_cur  = {1'b0, out};
  assign w_inc  = w_cur + (W+1)'(1);
  assign w_dec  = w_cur - (W+1)'(1);
  assign w_load = W'(clamp_load(int'(load_val), MOD));

  always_comb begin
    next_out  = out;
    wrap_next = 1'b0;
    if (clr) begin
      next_out = '0;
    end else if (load) begin
      next_out = w_load;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (w_inc >= LP_MOD) begin
`ifdef SYNC_UPDOWN_SAT_EN
          next_out  = LP_TOP;
`else
          next_out  = '0;
          wrap_next = 1'b1;
`endif
        end else begin
          next_out = w_inc[W-1:0];
        end
      end else begin
        if (w_dec[W]) begin
`ifdef SYNC_UPDOWN_SAT_EN
          next_out  = '0;
`else
          next_out  = LP_TOP;
          wrap_next = 1'b1;
`endif
        end else begin
          next_out = w_dec[W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo up/down counter with load, clear, terminal count and wrap pulse.
// Define SYNC_UPDOWN_SAT_EN to saturate at the ends instead of wrapping.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up_dn,
  output logic [W-1:0] out,
  output logic         tc,
  output logic         wrap
);

  logic [W-1:0] r_out;
  logic         r_wrap;
  logic [W-1:0] w_next_out;
  logic         w_wrap_next;
  logic         w_at_end;

  counter_next_state #(
    .W   (W),
    .MOD (MOD)
  ) u_next_state (
    .out       (r_out),
    .up_dn     (up_dn),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .next_out  (w_next_out),
    .wrap_next (w_wrap_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_wrap <= w_wrap_next;
    end
  end

  // tc looks ahead at the coming edge so a cascaded stage can use it as its enable.
  assign w_at_end = (up_dn == DIR_UP) ? (r_out == W'(MOD - 1)) : (r_out == '0);
  assign tc       = en & ~clr & ~load & w_at_end;
  assign out      = r_out;
  assign wrap     = r_wrap;

endmodule
